// File: rtl/buffer_pkg.sv
// Constants shared by the 64<->512 width-conversion buffers.
// Both directions take their lane geometry from this package.
package buffer_pkg;
    localparam int IN_W       = 64;
    localparam int OUT_W      = 512;
    localparam int LANES      = OUT_W / IN_W;
    localparam int LANE_IDX_W = 3;
    localparam int ASM_W      = IN_W * (LANES - 1);
endpackage

// File: rtl/buffer_lane_assembler.sv
// Packs 64-bit words into 512-bit lines, first word in lane 0.
// The final word is never stored; it is combined directly into the committed line.
module buffer_lane_assembler
    import buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  accept,
    input  logic [IN_W-1:0]       data_in,
    output logic [LANE_IDX_W-1:0] lane,
    output logic [OUT_W-1:0]      line,
    output logic                  commit
);
    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

    logic [LANE_IDX_W-1:0] lane_reg;
    logic [IN_W-1:0]       asm_word [LANES-1];
    logic [ASM_W-1:0]      asm_flat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_reg <= '0;
        end else if (clr) begin
            lane_reg <= '0;
        end else if (accept) begin
            lane_reg <= (lane_reg == LAST_LANE) ? '0 : lane_reg + 1'b1;
        end
    end

    // Each lane register loads only when the counter points at it.
    generate
        for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_lane
            logic [IN_W-1:0] word_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    word_reg <= '0;
                end else if (clr) begin
                    word_reg <= '0;
                end else if (accept && lane_reg == LANE_IDX_W'(gi)) begin
                    word_reg <= data_in;
                end
            end
            assign asm_word[gi] = word_reg;
            assign asm_flat[gi*IN_W +: IN_W] = word_reg;
        end
    endgenerate

    assign lane   = lane_reg;
    assign line   = {data_in, asm_flat};
    assign commit = accept && (lane_reg == LAST_LANE);
endmodule

// File: rtl/buffer_64_to_512.sv
// 64-to-512 width-up converter feeding a show-ahead FIFO of 512-bit lines.
// Flags and data_out depend only on registered state.
module buffer_64_to_512
    import buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [IN_W-1:0]  data_in,
    input  logic             wr_enable,
    output logic [OUT_W-1:0] data_out,
    input  logic             rd_enable,
    output logic             full,
    output logic             empty,
    output logic             full_n
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [OUT_W-1:0]      mem_word [DEPTH];
    logic [LANE_IDX_W-1:0] lane;
    logic [OUT_W-1:0]      line;
    logic                  commit;
    logic                  accept;
    logic                  pop;

    assign accept = wr_enable && !full;
    assign pop    = rd_enable && !empty;

    buffer_lane_assembler u_assembler (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .accept  (accept),
        .data_in (data_in),
        .lane    (lane),
        .line    (line),
        .commit  (commit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (commit) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({commit, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Line storage is cleared by reset, so it lives in registers rather than RAM.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [OUT_W-1:0] entry_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry_reg <= '0;
                end else if (clr) begin
                    entry_reg <= '0;
                end else if (commit && wr_ptr_reg == PTR_W'(gi)) begin
                    entry_reg <= line;
                end
            end
            assign mem_word[gi] = entry_reg;
        end
    endgenerate

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH)) && (lane == LAST_LANE);
    assign full_n   = ~full;
    assign data_out = empty ? '0 : mem_word[rd_ptr_reg];
endmodule

// File: tb/tb_buffer_64_to_512.sv
// Directed and random checks of buffer_64_to_512 against a queue-based line model.
module tb_buffer_64_to_512;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic [63:0]  data_in = '0;
    logic         wr_enable = 1'b0;
    logic         rd_enable = 1'b0;
    logic [511:0] data_out;
    logic         full;
    logic         empty;
    logic         full_n;

    int total = 0;
    int bad   = 0;

    logic [511:0] q_lines [$];
    logic [63:0]  q_pend  [$];

    buffer_64_to_512 #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .data_in   (data_in),
        .wr_enable (wr_enable),
        .data_out  (data_out),
        .rd_enable (rd_enable),
        .full      (full),
        .empty     (empty),
        .full_n    (full_n)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] seq(input int s);
        logic [511:0] r;
        for (int k = 0; k < 8; k++) r[k*64 +: 64] = 64'(s + k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic m_full;
        logic m_empty;
        m_empty = (q_lines.size() == 0);
        m_full  = (q_lines.size() == DEPTH) && (q_pend.size() == 7);
        chk({tag, ".data_out"}, data_out, m_empty ? 512'd0 : q_lines[0]);
        chk({tag, ".empty"}, 512'(empty), 512'(m_empty));
        chk({tag, ".full"}, 512'(full), 512'(m_full));
        chk({tag, ".full_n"}, 512'(full_n), 512'(!m_full));
    endtask

    task automatic model_clear();
        q_lines.delete();
        q_pend.delete();
    endtask

    task automatic model_edge(input logic w, input logic r, input logic c, input logic [63:0] d);
        logic         m_full;
        logic         m_empty;
        logic [511:0] ln;
        m_empty = (q_lines.size() == 0);
        m_full  = (q_lines.size() == DEPTH) && (q_pend.size() == 7);
        if (c) begin
            model_clear();
        end else begin
            if (r && !m_empty) void'(q_lines.pop_front());
            if (w && !m_full) begin
                q_pend.push_back(d);
                if (q_pend.size() == 8) begin
                    for (int k = 0; k < 8; k++) ln[k*64 +: 64] = q_pend[k];
                    q_lines.push_back(ln);
                    q_pend.delete();
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic w, input logic r, input logic c, input logic [63:0] d);
        wr_enable = w;
        rd_enable = r;
        clr       = c;
        data_in   = d;
        @(posedge clk);
        model_edge(w, r, c, d);
        #1;
        check_all(tag);
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        clr       = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        check_all("reset_held");
        @(negedge clk) rst = 1'b1;
        step("idle", 1'b0, 1'b0, 1'b0, 64'd0);

        // Single line: empty must stay high until the eighth word commits.
        for (int i = 1; i <= 8; i++) step("single", 1'b1, 1'b0, 1'b0, 64'(i));
        chk("single_line", data_out, seq(1));
        step("single_pop", 1'b0, 1'b1, 1'b0, 64'd0);

        for (int i = 1; i <= 24; i++) step("multi_wr", 1'b1, 1'b0, 1'b0, 64'(i));
        chk("multi_head0", data_out, seq(1));
        step("multi_rd", 1'b0, 1'b1, 1'b0, 64'd0);
        chk("multi_head1", data_out, seq(9));
        step("multi_rd", 1'b0, 1'b1, 1'b0, 64'd0);
        chk("multi_head2", data_out, seq(17));
        step("multi_rd", 1'b0, 1'b1, 1'b0, 64'd0);
        chk("multi_empty", 512'(empty), 512'd1);

        // Full boundary: four lines stored plus lanes 0..6 of a fifth.
        for (int i = 1; i <= 39; i++) step("fill", 1'b1, 1'b0, 1'b0, 64'(i));
        chk("full_after_39", 512'(full), 512'd1);
        step("drop40", 1'b1, 1'b0, 1'b0, 64'd40);
        chk("drop40_head", data_out, seq(1));
        step("free_one", 1'b0, 1'b1, 1'b0, 64'd0);
        chk("full_dropped", 512'(full), 512'd0);
        step("commit40", 1'b1, 1'b0, 1'b0, 64'd40);
        chk("full_after_40", 512'(full), 512'd0);
        for (int i = 0; i < 3; i++) step("drain", 1'b0, 1'b1, 1'b0, 64'd0);
        chk("line_33_40", data_out, seq(33));
        step("drain", 1'b0, 1'b1, 1'b0, 64'd0);

        // Commit and pop on the same edge.
        for (int i = 1; i <= 23; i++) step("conc_wr", 1'b1, 1'b0, 1'b0, 64'(i));
        step("conc_both", 1'b1, 1'b1, 1'b0, 64'd24);
        chk("conc_head", data_out, seq(9));
        step("conc_rd", 1'b0, 1'b1, 1'b0, 64'd0);
        chk("conc_second", data_out, seq(17));
        step("conc_rd", 1'b0, 1'b1, 1'b0, 64'd0);
        chk("conc_empty", 512'(empty), 512'd1);

        // Clear discards a partial line and dominates strobes.
        for (int i = 1; i <= 5; i++) step("pre_clr", 1'b1, 1'b0, 1'b0, 64'(100 + i));
        step("clr", 1'b1, 1'b1, 1'b1, 64'd99);
        for (int i = 1; i <= 8; i++) step("post_clr", 1'b1, 1'b0, 1'b0, 64'(i));
        chk("clr_line", data_out, seq(1));

        // Asynchronous reset between edges.
        for (int i = 1; i <= 3; i++) step("pre_rst", 1'b1, 1'b0, 1'b0, 64'(i));
        #2 rst = 1'b0;
        #1;
        model_clear();
        check_all("async_rst");
        @(negedge clk) rst = 1'b1;
        step("after_rst", 1'b0, 1'b1, 1'b0, 64'd0);

        for (int n = 0; n < 400; n++) begin
            step("rand",
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 99) < 2),
                 {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/buffer_64_to_512.md
# buffer_64_to_512

Width-up converter and storage buffer, the write-side counterpart of the existing 512-to-64 read buffer. It accepts a stream of 64-bit words, packs each group of eight into one 512-bit line (first word in the least-significant lane), and queues the lines in a small FIFO. The output is show-ahead, and a 512-bit consumer pops it one line at a time. It sits between 64-bit producers (processing cores, host PIO) and the 512-bit memory/CCI write path.

## Interface
- DEPTH, 4: number of 512-bit lines stored; power of two, ≥2.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-low; clears all state.
- clr  in  1  synchronous clear, active-high; same effect as reset, on the next edge.
- data_in  in  64  input word.
- wr_enable  in  1  write strobe; one word accepted per cycle when high and !full.
- data_out  out  512  head line; lane k = bits [64k+63:64k].
- rd_enable  in  1  pop strobe; one line removed per cycle when high and !empty.
- full  out  1  next write cannot be accepted.
- empty  out  1  no complete line available.
- full_n  out  1  always ~full.

## Operation
- State:
  - lane counter `lane` (0..7);
  - 448-bit assembly register holding lanes 0..6;
  - DEPTH×512 line memory;
  - read/write pointers, log2(DEPTH) bits, wrapping modulo DEPTH;
  - line count (0..DEPTH).
- Accepted write, lane < 7: data_in is stored in assembly lane `lane`; lane increments.
- Accepted write, lane = 7 (commit):
  - {data_in, assembly[447:0]} is written to mem[wr_ptr];
  - wr_ptr increments; count increments; lane returns to 0;
  - the assembly register is not cleared (it is overwritten lane by lane).
- Accepted read: rd_ptr increments; count decrements.
- Commit and read in the same cycle: both pointers advance; count is unchanged.
- full = (count == DEPTH) && (lane == 7).
  - Lanes 0..6 of the next line still accumulate while the memory is full.
  - A write while full is dropped; lane and the assembly register are unchanged.
- A write while full together with a read in the same cycle is still dropped. full is evaluated before the edge and is not forwarded from the read.
- empty = (count == 0).
  - A read while empty is ignored.
  - A partial line (lane > 0) never makes empty low.
- data_out = mem[rd_ptr] when !empty, else 512'd0.
- clr dominates wr_enable and rd_enable in the same cycle.
- rst asserted mid-operation: state clears immediately and asynchronously; partial and stored data are lost.
- Reset values: data_out = 0, full = 0, empty = 1, full_n = 1, lane = 0, pointers = 0, count = 0; memory contents are zeroed.

## Timing
- Write-to-visible latency is 1 cycle. After the edge that accepts the 8th word, empty = 0 and data_out shows the new line in that cycle.
- Read: data_out advances to the next line (or 0) immediately after the accepting edge.
- Throughput: one 64-bit write and one 512-bit read per cycle, concurrently.
- full, empty, full_n and data_out are combinational from registered state only. There are no input-to-output combinational paths.

## Structure
- Shared package buffer_pkg holds:
  - IN_W = 64, OUT_W = 512;
  - LANES = OUT_W / IN_W = 8;
  - LANE_IDX_W = 3.
- The existing 512-to-64 buffer imports the same constants.
- One sub-module, buffer_lane_assembler, contains the lane counter and assembly register. It outputs a 512-bit line plus a commit pulse.
- The FIFO memory, pointers and flags stay in the top module.

## Test plan
- Reset to idle:
  - stimulus: hold rst low, then release; apply no writes;
  - required: empty = 1, full = 0, full_n = 1, data_out = 0.
- Single line:
  - stimulus: write 1..8 on consecutive cycles;
  - required: empty falls after the 8th edge; data_out = {64'd8, 64'd7, …, 64'd1}.
- Multiple lines:
  - stimulus: write 1..24, then 3 reads;
  - required: the lines {8..1}, {16..9}, {24..17} appear in order; empty = 1 after the 3rd read.
- Full boundary (DEPTH = 4):
  - stimulus: write 1..39, then write 40;
  - required: full = 0 through word 38; full = 1 after word 39; word 40 is dropped.
  - stimulus: one read, then write 40;
  - required: full drops after the read; word 40 commits line {40..33}; full = 0 afterwards.
- Concurrency:
  - stimulus: with 2 lines stored and lane = 7, assert write and read in the same cycle;
  - required: count stays 2; data_out moves to the second line.
- Clear and reset mid-operation:
  - stimulus: write 5 words, pulse clr, then write 1..8;
  - required: the first stored line is exactly {8..1}.
  - stimulus: assert rst between edges mid-stream;
  - required: all flags return to their reset values without waiting for a clock edge.
